// File: rtl/ft600_tx_arbiter_if.sv
// ft600_tx_arbiter_if: requester side and TX FIFO write side of the arbiter.
// master = arbiter, slave = requesters/FIFO.
interface ft600_tx_arbiter_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0]    ch_valid;
   logic [16*NUM_CH-1:0] ch_data;
   logic [NUM_CH-1:0]    ch_ready;
   logic                 tx_en;
   logic [15:0]          tx_in;
   logic                 tx_full;
   logic [NUM_CH-1:0]    grant;
   logic                 busy;

   modport master (
      input  ch_valid, ch_data, tx_full,
      output ch_ready, tx_en, tx_in, grant, busy
   );

   modport slave (
      output ch_valid, ch_data, tx_full,
      input  ch_ready, tx_en, tx_in, grant, busy
   );
endinterface

// File: rtl/ft600_tx_arbiter.sv
// ft600_tx_arbiter: round-robin burst arbiter onto the ft600_mode245 TX FIFO.
// Define FT_TX_HEADER_EN to prefix each burst with an {8'hA5, channel} word.
module ft600_tx_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int MAX_BURST = 64
) (
   input logic                clk,
   input logic                rst,
   ft600_tx_arbiter_if.master bus
);
   localparam int GW = $clog2(NUM_CH);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

   state_t        state, state_nx;
   logic [GW-1:0] g, g_nx;
   logic [GW-1:0] last, last_nx;
   logic [GW-1:0] pick;
   logic [CW-1:0] cnt, cnt_nx;
   logic          any_req;
   logic          own_valid;
   logic          wr;
   logic [15:0]   own_data;

   assign any_req   = |bus.ch_valid;
   assign own_valid = bus.ch_valid[g];
   assign own_data  = bus.ch_data[{g, 4'b0000} +: 16];
   assign wr        = own_valid & ~bus.tx_full;

   // scan last+1, last+2, ... ; the nearest requester wins
   always_comb begin
      logic [GW-1:0] idx;
      idx  = '0;
      pick = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = GW'((int'(last) + k) % NUM_CH);
         if (bus.ch_valid[idx])
            pick = idx;
      end
   end

   // owner indication
   always_comb begin
      bus.busy  = (state != IDLE);
      bus.grant = '0;
      if (state != IDLE)
         bus.grant[g] = 1'b1;
   end

   // next state and FIFO write port
   always_comb begin
      state_nx     = state;
      g_nx         = g;
      last_nx      = last;
      cnt_nx       = cnt;
      bus.tx_en    = 1'b0;
      bus.tx_in    = '0;
      bus.ch_ready = '0;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               g_nx   = pick;
               cnt_nx = '0;
`ifdef FT_TX_HEADER_EN
               state_nx = HEADER;
`else
               state_nx = DATA;
`endif
            end
         end
`ifdef FT_TX_HEADER_EN
         HEADER: begin
            bus.tx_en = ~bus.tx_full;
            bus.tx_in = {8'hA5, 8'(g)};
            if (!bus.tx_full)
               state_nx = DATA;
         end
`endif
         DATA: begin
            bus.tx_en       = wr;
            bus.tx_in       = own_data;
            bus.ch_ready[g] = wr;
            if (wr)
               cnt_nx = cnt + 1'b1;
            // a source gap or a full burst hands the port back
            if (!own_valid || (wr && cnt == CNT_LAST)) begin
               state_nx = IDLE;
               last_nx  = g;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // state registers; channel 0 has first priority after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         g     <= '0;
         last  <= GW'(NUM_CH - 1);
         cnt   <= '0;
      end else begin
         state <= state_nx;
         g     <= g_nx;
         last  <= last_nx;
         cnt   <= cnt_nx;
      end
   end
endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// tb_ft600_tx_arbiter: directed scenarios plus randomized traffic
// against a burst-level reference model of the arbiter.
module tb_ft600_tx_arbiter;
   localparam int NC = 4;
   localparam int MB = 4;
`ifdef FT_TX_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam logic [15:0] FIRST = (HDR != 0) ? 16'hA500 : 16'h0000;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   int          src_left [NC];
   logic [11:0] src_cnt  [NC];
   logic [NC-1:0] gap;
   logic [15:0] fifo_q [$];

   ft600_tx_arbiter_if #(.NUM_CH(NC)) bus ();

   ft600_tx_arbiter #(.NUM_CH(NC), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   task automatic drive();
      for (int i = 0; i < NC; i++) begin
         bus.ch_valid[i]        = (src_left[i] > 0) && !gap[i];
         bus.ch_data[16*i +: 16] = {4'(i), src_cnt[i]};
      end
   endtask

   // log the FIFO write, cross the edge, then pop the consumed words
   task automatic step();
      logic [NC-1:0] rdy;
      rdy = bus.ch_ready;
      if (bus.tx_en) fifo_q.push_back(bus.tx_in);
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
         if (rdy[i]) begin
            src_cnt[i]++;
            if (src_left[i] > 0) src_left[i]--;
         end
      end
      drive();
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.tx_full = 1'b0;
      gap         = '0;
      for (int i = 0; i < NC; i++) begin
         src_left[i] = 0;
         src_cnt[i]  = '0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      fifo_q.delete();
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.tx_full = 1'b0;
      gap         = '0;
      for (int i = 0; i < NC; i++) begin
         src_left[i] = 0;
         src_cnt[i]  = '0;
      end
      drive();
      @(negedge clk);
      checks++;
      if (bus.tx_en !== 1'b0) begin
         errors++; $display("FAIL reset_tx_en got=%b exp=0", bus.tx_en);
      end
      checks++;
      if (bus.tx_in !== 16'h0000) begin
         errors++; $display("FAIL reset_tx_in got=%h exp=0000", bus.tx_in);
      end
      checks++;
      if (bus.ch_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ch_ready got=%b exp=0000", bus.ch_ready);
      end
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++; $display("FAIL reset_grant got=%b exp=0000", bus.grant);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
      end
      for (int i = 0; i < NC; i++) src_left[i] = 1000;
      drive();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.tx_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_held busy=%b tx_en=%b exp=0/0", bus.busy, bus.tx_en);
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy);
      end
      step();
   endtask

   task automatic test_round_robin();
      localparam int C = 30;
      localparam int P = MB + 1 + HDR;
      localparam int W = MB + HDR;
      logic [15:0] exp_q [$];
      int exp_n;
      do_reset();
      src_left[0] = 1000;
      src_left[2] = 1000;
      drive();
      for (int k = 0; k < C; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (bus.grant !== 4'b0001) begin
               errors++; $display("FAIL rr_first_grant got=%b exp=0001", bus.grant);
            end
         end
         step();
      end
      for (int b = 0; b < 12; b++) begin
         int ch;
         ch = (b % 2 == 0) ? 0 : 2;
         if (HDR != 0) exp_q.push_back({8'hA5, 8'(ch)});
         for (int w = 0; w < MB; w++)
            exp_q.push_back({4'(ch), 12'((b / 2) * MB + w)});
      end
      exp_n = (C / P) * W + (((C % P) > 1) ? (C % P) - 1 : 0);
      checks++;
      if (fifo_q.size() != exp_n) begin
         errors++;
         $display("FAIL rr_word_count got=%0d exp=%0d", fifo_q.size(), exp_n);
      end
      for (int j = 0; j < exp_n && j < fifo_q.size(); j++) begin
         checks++;
         if (fifo_q[j] !== exp_q[j]) begin
            errors++;
            $display("FAIL rr_word[%0d] got=%h exp=%h", j, fifo_q[j], exp_q[j]);
         end
      end
   endtask

   task automatic test_gap();
      localparam int RA = 4 + HDR;
      logic [15:0] exp_q [$];
      do_reset();
      src_left[1] = 2;
      src_left[3] = 4;
      drive();
      for (int k = 0; k < 40; k++) begin
         if (k == RA) begin
            src_left[1] = 2;
            drive();
         end
         @(negedge clk);
         step();
      end
      if (HDR != 0) exp_q.push_back(16'hA501);
      exp_q.push_back(16'h1000);
      exp_q.push_back(16'h1001);
      if (HDR != 0) exp_q.push_back(16'hA503);
      for (int w = 0; w < 4; w++) exp_q.push_back({4'd3, 12'(w)});
      if (HDR != 0) exp_q.push_back(16'hA501);
      exp_q.push_back(16'h1002);
      exp_q.push_back(16'h1003);
      checks++;
      if (fifo_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL gap_word_count got=%0d exp=%0d", fifo_q.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < fifo_q.size(); j++) begin
         checks++;
         if (fifo_q[j] !== exp_q[j]) begin
            errors++;
            $display("FAIL gap_word[%0d] got=%h exp=%h", j, fifo_q[j], exp_q[j]);
         end
      end
   endtask

   task automatic test_full_stall();
      localparam int N = 2 * (MB + HDR);
      logic [15:0] exp_q [$];
      do_reset();
      src_left[0] = 1000;
      drive();
      for (int k = 0; k < 31; k++) begin
         bus.tx_full = (k >= 2 + HDR) && (k < 12 + HDR);
         @(negedge clk);
         if (bus.tx_full) begin
            checks++;
            if (bus.tx_en !== 1'b0) begin
               errors++; $display("FAIL stall_tx_en k=%0d got=%b exp=0", k, bus.tx_en);
            end
            checks++;
            if (bus.ch_ready !== 4'b0000) begin
               errors++;
               $display("FAIL stall_ready k=%0d got=%b exp=0000", k, bus.ch_ready);
            end
            checks++;
            if (bus.grant !== 4'b0001) begin
               errors++;
               $display("FAIL stall_grant k=%0d got=%b exp=0001", k, bus.grant);
            end
         end
         step();
      end
      bus.tx_full = 1'b0;
      for (int b = 0; b < 2; b++) begin
         if (HDR != 0) exp_q.push_back(16'hA500);
         for (int w = 0; w < MB; w++) exp_q.push_back({4'd0, 12'(b * MB + w)});
      end
      checks++;
      if (fifo_q.size() < N) begin
         errors++;
         $display("FAIL stall_word_count got=%0d exp>=%0d", fifo_q.size(), N);
      end
      for (int j = 0; j < N && j < fifo_q.size(); j++) begin
         checks++;
         if (fifo_q[j] !== exp_q[j]) begin
            errors++;
            $display("FAIL stall_word[%0d] got=%h exp=%h", j, fifo_q[j], exp_q[j]);
         end
      end
   endtask

`ifdef FT_TX_HEADER_EN
   task automatic test_header_stall();
      do_reset();
      src_left[2]  = 1000;
      bus.tx_full  = 1'b1;
      drive();
      for (int k = 0; k < 6; k++) begin
         if (k == 4) bus.tx_full = 1'b0;
         @(negedge clk);
         if (k >= 1 && k <= 3) begin
            checks++;
            if (bus.tx_en !== 1'b0 || bus.grant !== 4'b0100) begin
               errors++;
               $display("FAIL hdr_stall k=%0d tx_en=%b grant=%b exp=0/0100",
                        k, bus.tx_en, bus.grant);
            end
         end
         if (k == 4) begin
            checks++;
            if (bus.tx_en !== 1'b1 || bus.tx_in !== 16'hA502) begin
               errors++;
               $display("FAIL hdr_release tx_en=%b tx_in=%h exp=1/A502",
                        bus.tx_en, bus.tx_in);
            end
         end
         if (k == 5) begin
            checks++;
            if (bus.tx_in !== 16'h2000 || bus.ch_ready !== 4'b0100) begin
               errors++;
               $display("FAIL hdr_first_data tx_in=%h ready=%b exp=2000/0100",
                        bus.tx_in, bus.ch_ready);
            end
         end
         step();
      end
   endtask
`else
   task automatic test_no_header();
      do_reset();
      src_left[2] = 1000;
      drive();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            checks++;
            if (bus.busy !== 1'b0) begin
               errors++; $display("FAIL nohdr_idle busy=%b exp=0", bus.busy);
            end
         end
         if (k == 1) begin
            checks++;
            if (bus.grant !== 4'b0100 || bus.tx_en !== 1'b1 ||
                bus.tx_in !== 16'h2000 || bus.ch_ready !== 4'b0100) begin
               errors++;
               $display("FAIL nohdr_latency grant=%b tx_en=%b tx_in=%h ready=%b exp=0100/1/2000/0100",
                        bus.grant, bus.tx_en, bus.tx_in, bus.ch_ready);
            end
         end
         step();
      end
      checks++;
      if (fifo_q.size() != 16) begin
         errors++; $display("FAIL nohdr_count got=%0d exp=16", fifo_q.size());
      end
      for (int j = 0; j < fifo_q.size(); j++) begin
         checks++;
         if (fifo_q[j] !== {4'd2, 12'(j)}) begin
            errors++;
            $display("FAIL nohdr_word[%0d] got=%h exp=%h", j, fifo_q[j], {4'd2, 12'(j)});
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      src_left[2] = 1000;
      drive();
      for (int k = 0; k < 2 + HDR; k++) begin
         @(negedge clk);
         step();
      end
      @(negedge clk);
      checks++;
      if (bus.tx_en !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre tx_en=%b exp=1", bus.tx_en);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.tx_en !== 1'b0 || bus.ch_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_drop tx_en=%b ready=%b exp=0/0000", bus.tx_en, bus.ch_ready);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_grant busy=%b grant=%b exp=0/0000", bus.busy, bus.grant);
      end
      @(posedge clk);
      #1;
      src_left[0] = 1000;
      drive();
      rst = 1'b0;
      fifo_q.delete();
      @(negedge clk);
      step();
      @(negedge clk);
      checks++;
      if (bus.grant !== 4'b0001 || bus.tx_en !== 1'b1 || bus.tx_in !== FIRST) begin
         errors++;
         $display("FAIL rstmid_regrant grant=%b tx_en=%b tx_in=%h exp=0001/1/%h",
                  bus.grant, bus.tx_en, bus.tx_in, FIRST);
      end
      step();
   endtask

   task automatic test_random();
      bit   m_busy = 1'b0;
      bit   m_hdr  = 1'b0;
      bit   found;
      int   m_own   = 0;
      int   m_last  = NC - 1;
      int   m_words = 0;
      logic [NC-1:0] v, e_ready, e_grant;
      logic          e_en, f;
      logic [15:0]   e_in;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NC; i++) begin
            if (src_left[i] == 0 && $urandom_range(3) == 0)
               src_left[i] = int'($urandom_range(6, 1));
            gap[i] = ($urandom_range(7) == 0);
         end
         bus.tx_full = ($urandom_range(4) == 0);
         drive();
         @(negedge clk);
         v = bus.ch_valid;
         f = bus.tx_full;
         e_grant = '0;
         if (m_busy) e_grant[m_own] = 1'b1;
         e_en    = m_busy && !f && (m_hdr || v[m_own]);
         e_in    = m_hdr ? {8'hA5, 8'(m_own)} : {4'(m_own), src_cnt[m_own]};
         e_ready = (e_en && !m_hdr) ? e_grant : '0;
         checks++;
         if (bus.busy !== m_busy) begin
            errors++; $display("FAIL rnd_busy k=%0d got=%b exp=%b", k, bus.busy, m_busy);
         end
         checks++;
         if (bus.grant !== e_grant) begin
            errors++; $display("FAIL rnd_grant k=%0d got=%b exp=%b", k, bus.grant, e_grant);
         end
         checks++;
         if (bus.tx_en !== e_en) begin
            errors++; $display("FAIL rnd_tx_en k=%0d got=%b exp=%b", k, bus.tx_en, e_en);
         end
         checks++;
         if (bus.ch_ready !== e_ready) begin
            errors++;
            $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, bus.ch_ready, e_ready);
         end
         if (e_en) begin
            checks++;
            if (bus.tx_in !== e_in) begin
               errors++; $display("FAIL rnd_tx_in k=%0d got=%h exp=%h", k, bus.tx_in, e_in);
            end
         end
         if (!m_busy) begin
            found = 1'b0;
            for (int s = 1; s <= NC; s++) begin
               if (!found && v[(m_last + s) % NC]) begin
                  found = 1'b1;
                  m_own = (m_last + s) % NC;
               end
            end
            if (found) begin
               m_busy  = 1'b1;
               m_hdr   = (HDR != 0);
               m_words = 0;
            end
         end else if (m_hdr) begin
            if (!f) m_hdr = 1'b0;
         end else if (!v[m_own]) begin
            m_busy = 1'b0;
            m_last = m_own;
         end else if (!f) begin
            m_words++;
            if (m_words == MB) begin
               m_busy = 1'b0;
               m_last = m_own;
            end
         end
         step();
      end
      bus.tx_full = 1'b0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_gap();
      test_full_stall();
`ifdef FT_TX_HEADER_EN
      test_header_stall();
`else
      test_no_header();
`endif
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
